// File: rtl/disp_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | disp_scan : six-digit multiplexed 7-segment scanner with frame snapshot  |
// |             and optional alarm blink (enable with DISP_SCAN_BLINK_EN).   |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module disp_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_u,
  input  logic [3:0] sec_t,
  input  logic [3:0] min_u,
  input  logic [3:0] min_t,
  input  logic [3:0] hr_u,
  input  logic [3:0] hr_t,
  input  logic       alarm,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int              c_dw       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_dw-1:0] c_div_last = c_dw'(SCAN_DIV - 1);
  localparam logic [c_dw-1:0] c_blank    = c_dw'(BLANK_CYC);

  logic [c_dw-1:0] r_div;
  logic [2:0]      r_idx;
  logic [23:0]     r_snap;
  logic            r_run;
  logic            w_slot_end;
  logic            w_frame_end;
  logic            w_blink_off;
  logic            w_on;
  logic [3:0]      w_digit;
  logic [6:0]      w_seg;

  assign w_slot_end  = (r_div == c_div_last);
  assign w_frame_end = w_slot_end && (r_idx == 3'd5);

  // r_run keeps the anodes dark while reset is held even when BLANK_CYC is 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      r_idx  <= 3'd0;
      r_snap <= 24'd0;
      r_run  <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_div <= w_slot_end ? '0 : r_div + c_dw'(1);
      if (w_slot_end) begin
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end
      if (w_frame_end) begin
        r_snap <= {hr_t, hr_u, min_t, min_u, sec_t, sec_u};
      end
    end
  end

`ifdef DISP_SCAN_BLINK_EN
  localparam int              c_fw        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_fw-1:0] c_fcnt_last = c_fw'(BLINK_FRAMES - 1);

  logic [c_fw-1:0] r_fcnt;
  logic            r_ph;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fcnt <= '0;
      r_ph   <= 1'b0;
    end else if (!alarm) begin
      r_fcnt <= '0;
      r_ph   <= 1'b0;
    end else if (w_frame_end) begin
      if (r_fcnt == c_fcnt_last) begin
        r_fcnt <= '0;
        r_ph   <= ~r_ph;
      end else begin
        r_fcnt <= r_fcnt + c_fw'(1);
      end
    end
  end

  // ph can only be high while alarm was held, so it alone gates the blink
  assign w_blink_off = r_ph;
`else
  localparam int c_unused_blink_frames = BLINK_FRAMES;
  logic w_unused_alarm;
  assign w_unused_alarm = alarm;
  assign w_blink_off    = 1'b0;
`endif

  assign w_on = r_run && (r_div >= c_blank) && !w_blink_off;

  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      3'd0:    w_digit = r_snap[3:0];
      3'd1:    w_digit = r_snap[7:4];
      3'd2:    w_digit = r_snap[11:8];
      3'd3:    w_digit = r_snap[15:12];
      3'd4:    w_digit = r_snap[19:16];
      3'd5:    w_digit = r_snap[23:20];
      default: w_digit = 4'd0;
    endcase
  end

  always_comb begin
    w_seg = 7'b0000000;
    case (w_digit)
      4'd0:    w_seg = 7'b0111111;
      4'd1:    w_seg = 7'b0000110;
      4'd2:    w_seg = 7'b1011011;
      4'd3:    w_seg = 7'b1001111;
      4'd4:    w_seg = 7'b1100110;
      4'd5:    w_seg = 7'b1101101;
      4'd6:    w_seg = 7'b1111101;
      4'd7:    w_seg = 7'b0000111;
      4'd8:    w_seg = 7'b1111111;
      4'd9:    w_seg = 7'b1101111;
      default: w_seg = 7'b0000000;
    endcase
  end

  assign an  = w_on ? ~(6'b000001 << r_idx) : 6'b111111;
  assign seg = w_on ? w_seg : 7'b0000000;
  assign dp  = w_on && ((r_idx == 3'd2) || (r_idx == 3'd4));

endmodule
`default_nettype wire

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per digit slot; legal range is BLANK_CYC+1 or more.
REQ-002 Parameter BLANK_CYC, default 16: cycles at the start of each slot with all anodes off (anti-ghosting); legal range is 0 or more.
REQ-003 Parameter BLINK_FRAMES, default 64: full scan frames per blink half-period; legal range is 1 or more.
REQ-004 clk  input  1  system clock, single clock domain; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 sec_u, sec_t, min_u, min_t, hr_u, hr_t  input  4 each  BCD time digits from the timekeeping counter.
REQ-007 alarm  input  1  alarm-active level from the timekeeping counter.
REQ-008 an  output  6  digit enables, active-low, at most one bit low at any time; bit 0 = sec_u, through bit 5 = hr_t.
REQ-009 seg  output  7  segments, active-high, bit order gfedcba (digit 0 = 0111111, 8 = 1111111).
REQ-010 dp  output  1  decimal point, active-high.

Function
REQ-011 Divider div SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-012 Slot index idx SHALL advance on the edge where div = SCAN_DIV-1, wrapping 5 -> 0.
REQ-013 On the edge where idx wraps 5 -> 0, a 24-bit snapshot SHALL load all six input digits simultaneously; the display SHALL show only snapshot values, so there is no tearing within a frame.
REQ-014 Input changes SHALL reach the display no earlier than the next frame start and no later than 6*SCAN_DIV cycles after that.
REQ-015 an SHALL be 111111 while div < BLANK_CYC; otherwise an[idx] = 0 and all other bits are 1.
REQ-016 seg SHALL be the decode of snapshot digit idx; values 10..15 decode to 0000000.
REQ-017 seg SHALL be 0000000 whenever an is 111111.
REQ-018 dp SHALL be 1 only when idx is 2 or 4 and the anode is on, giving hh.mm.ss separators.
REQ-019 an, seg and dp SHALL be combinational decodes of registered state only, with no direct input-to-output path.
REQ-020 Frame counter fcnt SHALL increment at each frame start (idx wrap); at BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink phase ph.

Reset
REQ-021 rst low SHALL immediately force div=0, idx=0, snapshot=0, fcnt=0, ph=0.
REQ-022 While rst is low, outputs SHALL be an=111111, seg=0000000, dp=0.
REQ-023 After rst deasserts, the first edge SHALL start slot 0 at div=1; if BLANK_CYC is 0, snapshot 000000 is shown until the first frame wrap.
REQ-024 Reset mid-slot or mid-frame SHALL abandon the slot or frame with no partial-state retention.

Configuration
REQ-025 Macro DISP_SCAN_BLINK_EN defined: while alarm=1 and ph=1, an SHALL be 111111 and seg 0000000 for the whole frame.
REQ-026 Under DISP_SCAN_BLINK_EN, alarm=0 SHALL clear fcnt and ph on the next edge.
REQ-027 Under DISP_SCAN_BLINK_EN, alarm is sampled each edge, and blanking takes effect the cycle after ph toggles.
REQ-028 Macro DISP_SCAN_BLINK_EN undefined: alarm SHALL be ignored, fcnt and ph SHALL not exist, and display is never blink-blanked.

Verification (SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2)
REQ-029 Reset: hold rst=0 with digits=123456 -> an=111111, seg=0, dp=0; release -> slot 0 on at div=1 showing 0 (0111111).
REQ-030 Scan order: digits hr_t..sec_u = 2,3,5,9,4,8 after one full frame -> per slot, an low bits 0..5 in order show seg 8,4,9,5,3,2; dp on slots 2 and 4 only; an 111111 at each div=0.
REQ-031 Snapshot: change sec_u 8->1 mid-frame at idx=3 -> slot 0 keeps 8 for the rest of the frame and shows 1 from the next frame.
REQ-032 Invalid BCD: min_u=4'hC -> slot 2 seg=0000000 with dp=1 and an[2]=0.
REQ-033 Blink (macro on): alarm=1 -> 2 frames normal, 2 frames an=111111, repeating; alarm=0 mid-blank -> normal display from the next cycle.
REQ-034 Blink (macro off): alarm=1 for 10 frames -> output identical to the alarm=0 run.
